// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the CPU bus responder: FSM encoding, SIZ codes,
// and the byte-lane enable logic for 32-bit and 16-bit ports.
package cpu_bus_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned LANES    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } bus_state_e;

  localparam logic [1:0] SIZ_LONG  = 2'b00;
  localparam logic [1:0] SIZ_BYTE  = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_3BYTE = 2'b11;

  // be[3] is lane 0 (bits 31:24), be[0] is lane 3 (bits 7:0).
  function automatic logic [LANES-1:0] lane_en(input logic [1:0] siz,
                                               input logic [1:0] a,
                                               input logic       port32);
    logic [1:0] half;
    logic [LANES-1:0] be;
    be   = '0;
    half = '0;
    if (port32) begin
      case (siz)
        SIZ_BYTE:  be = 4'b1000 >> a;
        SIZ_WORD:  be = a[1] ? 4'b0011 : 4'b1100;
        SIZ_3BYTE: be = (a == 2'b00) ? 4'b1110 : (4'b1111 >> a);
        default:   be = 4'b1111 >> a;
      endcase
    end else begin
      // 16-bit port: A1 picks the register half, A0 the byte within it.
      half = (siz == SIZ_BYTE) ? (a[0] ? 2'b01 : 2'b10) : 2'b11;
      be   = a[1] ? {2'b00, half} : {half, 2'b00};
    end
    return be;
  endfunction

  function automatic logic [DATA_W-1:0] lane_mask(input logic [LANES-1:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/bus_sync2.sv
// Two-flop synchroniser for an active-low asynchronous strobe; resets to the
// inactive (high) level.
module bus_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// Asynchronous-bus slave with four 32-bit registers: synchronises AS_/DS_,
// inserts programmable wait states and answers with DSACK on a 32- or 16-bit port.
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned WAITSTATES = 2,
  parameter bit          PORT32     = 1'b1
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              AS_,
  input  logic              DS_,
  input  logic              R_W,
  input  logic [1:0]        SIZ,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_OE,
  output logic              DSACK0_,
  output logic              DSACK1_,
  output logic              BUSY
);

  logic s_as;
  logic s_ds;

  bus_state_e        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              lat_rw, lat_rw_d;
  logic [1:0]        lat_siz, lat_siz_d;
  logic [ADDR_W-1:0] lat_addr, lat_addr_d;

  logic              dsack0_d, dsack1_d, oe_d, busy_d;
  logic [DATA_W-1:0] dout_d;
  logic              ack_entry;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [1:0]        idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] wr_mask;

  bus_sync2 u_sync_as (.clk(CLK), .rst_n(nRESET), .d(AS_), .q(s_as));
  bus_sync2 u_sync_ds (.clk(CLK), .rst_n(nRESET), .d(DS_), .q(s_ds));

  // Datapath views of the latched transfer; the 16-bit port uses DATA[31:16] only.
  always_comb begin
    idx     = lat_addr[3:2];
    rd_word = regs[idx];
    if (PORT32) begin
      rd_data = rd_word;
      wr_data = DATA_IN;
    end else begin
      rd_data = {(lat_addr[1] ? rd_word[15:0] : rd_word[31:16]), 16'h0000};
      wr_data = {DATA_IN[31:16], DATA_IN[31:16]};
    end
    wr_mask = lane_mask(lane_en(lat_siz, lat_addr[1:0], PORT32));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    lat_rw_d   = lat_rw;
    lat_siz_d  = lat_siz;
    lat_addr_d = lat_addr;
    dsack0_d   = DSACK0_;
    dsack1_d   = DSACK1_;
    oe_d       = DATA_OE;
    dout_d     = DATA_OUT;
    ack_entry  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!s_as) begin
          state_d    = ST_WAIT;
          cnt_d      = CNT_W'(WAITSTATES);
          lat_rw_d   = R_W;
          lat_siz_d  = SIZ;
          lat_addr_d = ADDR;
        end
      end
      ST_WAIT: begin
        if (s_as) begin
          state_d = ST_IDLE;
        end else if (cnt == '0) begin
          if (!s_ds) begin
            state_d   = ST_ACK;
            ack_entry = 1'b1;
            dsack1_d  = 1'b0;
            dsack0_d  = ~PORT32;
            if (lat_rw) begin
              oe_d   = 1'b1;
              dout_d = rd_data;
            end
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Only a negated AS_ ends the cycle; a re-assertion here is not seen.
        if (s_as) begin
          state_d  = ST_IDLE;
          dsack0_d = 1'b1;
          dsack1_d = 1'b1;
          oe_d     = 1'b0;
          dout_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lat_rw   <= 1'b1;
      lat_siz  <= SIZ_LONG;
      lat_addr <= '0;
      DSACK0_  <= 1'b1;
      DSACK1_  <= 1'b1;
      DATA_OE  <= 1'b0;
      BUSY     <= 1'b0;
      DATA_OUT <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      lat_rw   <= lat_rw_d;
      lat_siz  <= lat_siz_d;
      lat_addr <= lat_addr_d;
      DSACK0_  <= dsack0_d;
      DSACK1_  <= dsack1_d;
      DATA_OE  <= oe_d;
      BUSY     <= busy_d;
      DATA_OUT <= dout_d;
    end
  end

  // Register file: a write lands once, on the edge that enters ACK.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (ack_entry && !lat_rw) begin
      regs[idx] <= (regs[idx] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Scoreboard bench: three responders (32-bit WS=2, 16-bit WS=2, 32-bit WS=8)
// on a shared bus with per-device AS_; a monitor checks every DSACK against a queue.
module tb_cpu_bus_responder;

  typedef struct {
    logic [1:0]  id;
    logic        d0;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        nreset;
  logic [2:0]  as_n;
  logic        ds_n;
  logic        r_w;
  logic [1:0]  siz;
  logic [3:0]  addr;
  logic [31:0] din;
  logic [31:0] dout [3];
  logic [2:0]  oe, ds0, ds1, busy;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   lat;

  cpu_bus_responder #(.WAITSTATES(2), .PORT32(1'b1)) u_dut32 (
    .CLK(clk), .nRESET(nreset), .AS_(as_n[0]), .DS_(ds_n), .R_W(r_w), .SIZ(siz),
    .ADDR(addr), .DATA_IN(din), .DATA_OUT(dout[0]), .DATA_OE(oe[0]),
    .DSACK0_(ds0[0]), .DSACK1_(ds1[0]), .BUSY(busy[0]));

  cpu_bus_responder #(.WAITSTATES(2), .PORT32(1'b0)) u_dut16 (
    .CLK(clk), .nRESET(nreset), .AS_(as_n[1]), .DS_(ds_n), .R_W(r_w), .SIZ(siz),
    .ADDR(addr), .DATA_IN(din), .DATA_OUT(dout[1]), .DATA_OE(oe[1]),
    .DSACK0_(ds0[1]), .DSACK1_(ds1[1]), .BUSY(busy[1]));

  cpu_bus_responder #(.WAITSTATES(8), .PORT32(1'b1)) u_dut8 (
    .CLK(clk), .nRESET(nreset), .AS_(as_n[2]), .DS_(ds_n), .R_W(r_w), .SIZ(siz),
    .ADDR(addr), .DATA_IN(din), .DATA_OUT(dout[2]), .DATA_OE(oe[2]),
    .DSACK0_(ds0[2]), .DSACK1_(ds1[2]), .BUSY(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Monitor: every falling DSACK1_ must match the next queued expectation.
  initial begin
    logic [2:0] prev;
    exp_t e;
    prev = 3'b111;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (nreset && !ds1[2'(i)] && prev[2'(i)]) begin
          if (q.size() == 0) begin
            chk1("unexpected_ack", ds1[2'(i)], 1'b1);
          end else begin
            e = q.pop_front();
            chk("ack_device", 32'(i), 32'(e.id));
            chk1("dsack0", ds0[2'(i)], e.d0);
            chk1("data_oe", oe[2'(i)], e.rd);
            if (e.rd) chk("read_data", dout[2'(i)], e.data);
          end
        end
        prev[2'(i)] = ds1[2'(i)];
      end
    end
  end

  // One complete bus cycle; lat counts rising edges after the edge that first sees AS_ low.
  task automatic xfer(input logic [1:0] id, input logic rw, input logic [1:0] sz,
                      input logic [3:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, output int lt);
    exp_t e;
    int n;
    e.id = id; e.d0 = (id == 2'd1); e.rd = rw; e.data = exp_rd;
    q.push_back(e);
    @(negedge clk);
    r_w = rw; siz = sz; addr = a; din = wd;
    as_n[id] = 1'b0; ds_n = 1'b0;
    @(posedge clk);
    lt = 0;
    do begin
      @(posedge clk); #1; lt++;
    end while (ds1[id] && lt < 40);
    if (ds1[id]) chk1("ack_timeout", ds1[id], 1'b0);
    @(negedge clk);
    as_n[id] = 1'b1; ds_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (busy[id] && n < 20);
    chk1("busy_release", busy[id], 1'b0);
    chk1("dsack_release", ds1[id], 1'b1);
    chk1("oe_release", oe[id], 1'b0);
  endtask

  initial begin
    int n;
    logic seen;
    nreset = 1'b0; as_n = 3'b111; ds_n = 1'b1; r_w = 1'b1;
    siz = 2'b00; addr = 4'h0; din = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk1("rst_dsack0", ds0[2'(i)], 1'b1);
      chk1("rst_dsack1", ds1[2'(i)], 1'b1);
      chk1("rst_oe", oe[2'(i)], 1'b0);
      chk1("rst_busy", busy[2'(i)], 1'b0);
      chk("rst_dout", dout[2'(i)], 32'h0);
    end
    @(negedge clk); nreset = 1'b1;
    repeat (3) @(posedge clk);

    // 32-bit port, two wait states
    xfer(2'd0, 1'b0, 2'b01, 4'h6, 32'h00005A00, 32'h0, lat);
    xfer(2'd0, 1'b1, 2'b00, 4'h4, 32'h0, 32'h00005A00, lat);
    xfer(2'd0, 1'b0, 2'b00, 4'h4, 32'hDEADBEEF, 32'h0, lat);
    chk("write_latency", 32'(lat), 32'd5);
    xfer(2'd0, 1'b1, 2'b00, 4'h4, 32'h0, 32'hDEADBEEF, lat);
    chk("read_latency", 32'(lat), 32'd5);
    xfer(2'd0, 1'b0, 2'b10, 4'hA, 32'h0000CAFE, 32'h0, lat);
    xfer(2'd0, 1'b0, 2'b01, 4'hB, 32'h00000077, 32'h0, lat);
    xfer(2'd0, 1'b1, 2'b00, 4'h8, 32'h0, 32'h0000CA77, lat);
    xfer(2'd0, 1'b0, 2'b11, 4'hC, 32'h112233FF, 32'h0, lat);
    xfer(2'd0, 1'b1, 2'b00, 4'hC, 32'h0, 32'h11223300, lat);
    xfer(2'd0, 1'b0, 2'b11, 4'hD, 32'hFF445566, 32'h0, lat);
    xfer(2'd0, 1'b1, 2'b00, 4'hC, 32'h0, 32'h11445566, lat);

    // 16-bit port: data on bits 31:16 only
    xfer(2'd1, 1'b0, 2'b10, 4'h2, 32'h1234FFFF, 32'h0, lat);
    xfer(2'd1, 1'b1, 2'b10, 4'h2, 32'h0, 32'h12340000, lat);
    xfer(2'd1, 1'b1, 2'b10, 4'h0, 32'h0, 32'h00000000, lat);
    xfer(2'd1, 1'b0, 2'b01, 4'h3, 32'h00AB0000, 32'h0, lat);
    xfer(2'd1, 1'b0, 2'b01, 4'h0, 32'hC3000000, 32'h0, lat);
    xfer(2'd1, 1'b1, 2'b10, 4'h2, 32'h0, 32'h12AB0000, lat);
    xfer(2'd1, 1'b1, 2'b00, 4'h0, 32'h0, 32'hC3000000, lat);

    // Aborted cycle on the eight-wait-state device
    @(negedge clk);
    r_w = 1'b0; siz = 2'b00; addr = 4'h0; din = 32'hFFFFFFFF;
    as_n[2] = 1'b0; ds_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk1("abort_busy_in_wait", busy[2], 1'b1);
    @(negedge clk);
    as_n[2] = 1'b1; ds_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (!ds1[2] || !ds0[2]) seen = 1'b1;
    end
    chk1("abort_no_dsack", seen, 1'b0);
    chk1("abort_busy_idle", busy[2], 1'b0);
    xfer(2'd2, 1'b1, 2'b00, 4'h0, 32'h0, 32'h00000000, lat);
    chk("ws8_latency", 32'(lat), 32'd11);

    // Reset while the 32-bit device sits in ACK of a write
    @(negedge clk);
    r_w = 1'b0; siz = 2'b00; addr = 4'h0; din = 32'h99999999;
    as_n[0] = 1'b0; ds_n = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (ds1[0] && n < 40);
    chk1("rst_ack_dsack1_before", ds1[0], 1'b0);
    chk1("rst_ack_dsack0_before", ds0[0], 1'b0);
    nreset = 1'b0;
    #1;
    chk1("rst_ack_dsack0", ds0[0], 1'b1);
    chk1("rst_ack_dsack1", ds1[0], 1'b1);
    chk1("rst_ack_oe", oe[0], 1'b0);
    chk1("rst_ack_busy", busy[0], 1'b0);
    @(negedge clk);
    as_n[0] = 1'b1; ds_n = 1'b1;
    @(negedge clk); nreset = 1'b1;
    repeat (3) @(posedge clk);
    for (int r = 0; r < 4; r++) begin
      xfer(2'd0, 1'b1, 2'b00, 4'(r * 4), 32'h0, 32'h0, lat);
    end

    repeat (5) @(posedge clk);
    chk("pending_expectations", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
